// File: rtl/sp_ram_pkg.sv
// Shared helpers for sp_ram_arb: requester-id width, tag record width,
// packed-port field extraction and one-hot to index conversion.
package sp_ram_pkg;

  localparam int unsigned C_VEC_MAX   = 512;
  localparam int unsigned C_FIELD_MAX = 64;
  localparam int unsigned C_NREQ_MAX  = 8;

  // Width needed to index n requesters, never below one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Read-tag record is {valid, id}.
  function automatic int tag_width(input int idw);
    return 1 + idw;
  endfunction

  // Field idx of width w from a packed vector, zero-extended to C_FIELD_MAX.
  function automatic logic [C_FIELD_MAX-1:0] field_get(input logic [C_VEC_MAX-1:0] vec,
                                                      input int unsigned idx,
                                                      input int unsigned w);
    logic [C_FIELD_MAX-1:0] mask;
    mask = (w >= C_FIELD_MAX) ? '1 : ((C_FIELD_MAX'(1) << w) - C_FIELD_MAX'(1));
    return C_FIELD_MAX'(vec >> (idx * w)) & mask;
  endfunction

  function automatic int unsigned onehot_idx(input logic [C_NREQ_MAX-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < C_NREQ_MAX; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin grant; ptr is the last granted index and is held by the caller.
// Build macro SP_RAM_ARB_PRIO0_EN: requester 0 always wins, 1..G_NREQ-1 rotate among themselves.
module rr_arb #(
  parameter int G_NREQ = 2,
  parameter int G_IDW  = 1
) (
  input  logic [G_NREQ-1:0] req,
  input  logic [G_IDW-1:0]  ptr,
  output logic [G_NREQ-1:0] gnt
);

  // Distance of pos from start around a ring of the given size.
  function automatic int ring_dist(input int pos, input int start, input int size);
    return (pos >= start) ? pos - start : pos + size - start;
  endfunction

  always_comb begin
    int p;
    int s;
    gnt = '0;
    p   = int'(ptr);
`ifdef SP_RAM_ARB_PRIO0_EN
    // Requester i sits at ring position i-1; search starts just after ptr.
    s      = (p >= G_NREQ - 1) ? 0 : p;
    gnt[0] = req[0];
    for (int i = 1; i < G_NREQ; i++) begin
      gnt[i] = req[i] & ~req[0];
      for (int j = 1; j < G_NREQ; j++) begin
        if (req[j] && (ring_dist(j - 1, s, G_NREQ - 1) < ring_dist(i - 1, s, G_NREQ - 1)))
          gnt[i] = 1'b0;
      end
    end
`else
    s = (p >= G_NREQ - 1) ? 0 : p + 1;
    for (int i = 0; i < G_NREQ; i++) begin
      gnt[i] = req[i];
      for (int j = 0; j < G_NREQ; j++) begin
        if (req[j] && (ring_dist(j, s, G_NREQ) < ring_dist(i, s, G_NREQ)))
          gnt[i] = 1'b0;
      end
    end
`endif
  end

endmodule

// File: rtl/sp_ram_arb.sv
// Round-robin arbiter sharing one single-port RAM, with tagged fixed-latency read return.
// Build macro SP_RAM_ARB_PRIO0_EN gives requester 0 absolute priority.
module sp_ram_arb
  import sp_ram_pkg::*;
#(
  parameter int G_NREQ  = 2,
  parameter int G_ADDR  = 10,
  parameter int G_WIDTH = 16,
  parameter int G_RDLAT = 1,
  parameter int G_IDW   = clog2_min1(G_NREQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [G_NREQ-1:0]           req_vld,
  input  logic [G_NREQ-1:0]           req_we,
  input  logic [G_NREQ*G_ADDR-1:0]    req_addr,
  input  logic [G_NREQ*G_WIDTH-1:0]   req_din,
  output logic [G_NREQ-1:0]           req_rdy,
  output logic [G_NREQ-1:0]           rd_vld,
  output logic [G_WIDTH-1:0]          rd_dat,
  input  logic                        ram_clrrdy,
  output logic                        ram_we,
  output logic [G_ADDR-1:0]           ram_addr,
  output logic [G_WIDTH-1:0]          ram_din,
  input  logic [G_WIDTH-1:0]          ram_dout
);

  localparam int C_TAG_W = tag_width(G_IDW);

  logic [G_NREQ-1:0]  req_elig;
  logic [G_NREQ-1:0]  gnt;
  logic               any_gnt;
  int unsigned        gnt_idx;

  logic [G_IDW-1:0]   ptr_q, ptr_d;
  logic               ram_we_q, ram_we_d;
  logic [G_ADDR-1:0]  ram_addr_q, ram_addr_d;
  logic [G_WIDTH-1:0] ram_din_q, ram_din_d;
  logic [C_TAG_W-1:0] tag_q [G_RDLAT+1];
  logic [C_TAG_W-1:0] tag_d [G_RDLAT+1];

  // Grants depend only on valid, pointer and clear status, never on the payload.
  assign req_elig = req_vld & {G_NREQ{ram_clrrdy}};

  rr_arb #(
    .G_NREQ (G_NREQ),
    .G_IDW  (G_IDW)
  ) u_rr_arb (
    .req (req_elig),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign req_rdy = gnt & {G_NREQ{rst_n}};

  always_comb begin
    any_gnt    = |gnt;
    gnt_idx    = onehot_idx(C_NREQ_MAX'(gnt));
    ptr_d      = ptr_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (any_gnt) begin
      ram_we_d   = |(req_we & gnt);
      ram_addr_d = G_ADDR'(field_get(C_VEC_MAX'(req_addr), gnt_idx, G_ADDR));
      ram_din_d  = G_WIDTH'(field_get(C_VEC_MAX'(req_din), gnt_idx, G_WIDTH));
`ifdef SP_RAM_ARB_PRIO0_EN
      if (!gnt[0]) ptr_d = G_IDW'(gnt_idx);
`else
      ptr_d = G_IDW'(gnt_idx);
`endif
    end
    tag_d[0] = {any_gnt & ~ram_we_d, G_IDW'(gnt_idx)};
    for (int k = 1; k <= G_RDLAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= G_IDW'(G_NREQ - 1);
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      for (int k = 0; k <= G_RDLAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      for (int k = 0; k <= G_RDLAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

  // The last tag stage lines up with the RAM's dout for the same read.
  always_comb begin
    rd_vld = '0;
    for (int i = 0; i < G_NREQ; i++) begin
      if (tag_q[G_RDLAT][C_TAG_W-1] && (tag_q[G_RDLAT][G_IDW-1:0] == G_IDW'(i)))
        rd_vld[i] = 1'b1;
    end
  end

  assign rd_dat = ram_dout;

endmodule

// File: tb/tb_sp_ram_arb.sv
// Self-checking bench for sp_ram_arb with a behavioural RAM and a reference model
// (grant order, shadow memory, expected read-return queue).
module tb_sp_ram_arb;
`ifdef SP_RAM_ARB_PRIO0_EN
  localparam int NREQ = 3;
`else
  localparam int NREQ = 2;
`endif
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int RDLAT = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_vld = '0;
  logic [NREQ-1:0]      req_we = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_din = '0;
  logic [NREQ-1:0]      req_rdy;
  logic [NREQ-1:0]      rd_vld;
  logic [DW-1:0]        rd_dat;
  logic                 ram_clrrdy = 1'b1;
  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_din;
  logic [DW-1:0]        ram_dout;

  int checks = 0;
  int failures = 0;

  sp_ram_arb #(
    .G_NREQ  (NREQ),
    .G_ADDR  (AW),
    .G_WIDTH (DW),
    .G_RDLAT (RDLAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .req_rdy    (req_rdy),
    .rd_vld     (rd_vld),
    .rd_dat     (rd_dat),
    .ram_clrrdy (ram_clrrdy),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with RDLAT cycles address-to-dout.
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] pipe   [0:RDLAT-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    pipe[0] <= mem[ram_addr];
    for (int k = 1; k < RDLAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_dout = pipe[RDLAT-1];

  // Reference model
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] dat;
  } ret_t;

  ret_t expq[$];
  int   m_ptr = NREQ - 1;
  int   cyc = 0;

  function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] v, input int ptr,
                                                input logic clr);
    logic [NREQ-1:0] g;
    g = '0;
    if (!clr) return g;
`ifdef SP_RAM_ARB_PRIO0_EN
    if (v[0]) begin
      g[0] = 1'b1;
      return g;
    end
`endif
    for (int off = 1; off <= NREQ; off++) begin
      int c;
      c = (ptr + off) % NREQ;
`ifdef SP_RAM_ARB_PRIO0_EN
      if (c == 0) continue;
`endif
      if (v[c]) begin
        g[c] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    logic [NREQ-1:0] g;
    logic [AW-1:0]   a;
    if (!rst_n) begin
      m_ptr = NREQ - 1;
      expq.delete();
    end else begin
      g = model_gnt(req_vld, m_ptr, ram_clrrdy);
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          a = req_addr[i*AW +: AW];
          if (req_we[i]) shadow[a] = req_din[i*DW +: DW];
          else expq.push_back('{cyc + 1 + RDLAT, i, shadow[a]});
`ifdef SP_RAM_ARB_PRIO0_EN
          if (i != 0) m_ptr = i;
`else
          m_ptr = i;
`endif
        end
      end
    end
  end

  // Continuous scoreboard on grants and read returns, sampled mid-cycle.
  always @(negedge clk) begin
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_vld;
    logic [DW-1:0]   e_dat;
    e_rdy = rst_n ? model_gnt(req_vld, m_ptr, ram_clrrdy) : '0;
    e_vld = '0;
    e_dat = '0;
    while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e_vld[expq[0].id] = 1'b1;
      e_dat = expq[0].dat;
      void'(expq.pop_front());
    end
    checks++;
    if (req_rdy !== e_rdy) begin
      failures++;
      $display("FAIL sb_req_rdy cyc=%0d got=%b exp=%b", cyc, req_rdy, e_rdy);
    end
    checks++;
    if (rd_vld !== e_vld) begin
      failures++;
      $display("FAIL sb_rd_vld cyc=%0d got=%b exp=%b", cyc, rd_vld, e_vld);
    end
    if (e_vld != '0) begin
      checks++;
      if (rd_dat !== e_dat) begin
        failures++;
        $display("FAIL sb_rd_dat cyc=%0d got=%h exp=%h", cyc, rd_dat, e_dat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_vld[i]           = v;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_din[i*DW +: DW]  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_vld = '1;
    req_we = '0;
    ram_clrrdy = 1'b1;
    repeat (3) tick();
    checks++;
    if (req_rdy !== '0) begin failures++; $display("FAIL rst_req_rdy got=%b exp=0", req_rdy); end
    checks++;
    if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
    checks++;
    if (ram_addr !== '0) begin failures++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); end
    checks++;
    if (ram_din !== '0) begin failures++; $display("FAIL rst_ram_din got=%h exp=0", ram_din); end
    checks++;
    if (rd_vld !== '0) begin failures++; $display("FAIL rst_rd_vld got=%b exp=0", rd_vld); end
    rst_n = 1'b1;
    req_vld = '0;
    #1;
    checks++;
    if (req_rdy !== '0) begin failures++; $display("FAIL rel_req_rdy got=%b exp=0", req_rdy); end
    tick();
  endtask

  task automatic test_rr_start();
`ifdef SP_RAM_ARB_PRIO0_EN
    localparam int LEN = 7;
    logic [NREQ-1:0] vseq [LEN];
    logic [NREQ-1:0] eseq [LEN];
    vseq = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b110};
    eseq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010};
`else
    localparam int LEN = 4;
    logic [NREQ-1:0] vseq [LEN];
    logic [NREQ-1:0] eseq [LEN];
    vseq = '{2'b11, 2'b11, 2'b11, 2'b11};
    eseq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    req_we = '0;
    req_addr = '0;
    for (int i = 0; i < LEN; i++) begin
      req_vld = vseq[i];
      #1;
      checks++;
      if (req_rdy !== eseq[i]) begin
        failures++;
        $display("FAIL rr_step%0d got=%b exp=%b", i, req_rdy, eseq[i]);
      end
      tick();
    end
    req_vld = '0;
    repeat (RDLAT + 2) tick();
  endtask

  task automatic test_wr_rd();
    set_req(0, 1'b1, 1'b1, AW'(5), 16'h1234);
    #1;
    checks++;
    if (req_rdy !== NREQ'(1)) begin failures++; $display("FAIL wr_grant got=%b exp=%b", req_rdy, NREQ'(1)); end
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, AW'(5), '0);
    #1;
    checks++;
    if (req_rdy !== NREQ'(2)) begin failures++; $display("FAIL rd_grant got=%b exp=%b", req_rdy, NREQ'(2)); end
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, AW'(5), 16'h1234}) begin
      failures++;
      $display("FAIL wr_cmd got=%b/%h/%h exp=1/005/1234", ram_we, ram_addr, ram_din);
    end
    tick();
    req_vld = '0;
    #1;
    checks++;
    if (rd_vld !== '0) begin failures++; $display("FAIL wr_rd_early got=%b exp=0", rd_vld); end
    checks++;
    if ({ram_we, ram_addr} !== {1'b0, AW'(5)}) begin
      failures++;
      $display("FAIL rd_cmd got=%b/%h exp=0/005", ram_we, ram_addr);
    end
    tick();
    #1;
    checks++;
    if (rd_vld !== NREQ'(2)) begin failures++; $display("FAIL wr_rd_vld got=%b exp=%b", rd_vld, NREQ'(2)); end
    checks++;
    if (rd_dat !== 16'h1234) begin failures++; $display("FAIL wr_rd_dat got=%h exp=1234", rd_dat); end
    tick();
  endtask

  task automatic test_back_to_back();
    localparam int NC = 3 + RDLAT + 3;
    logic [DW-1:0] vals [3];
    logic          ov [NC];
    logic [DW-1:0] od [NC];
    vals = '{16'hA001, 16'hB002, 16'hC003};
    req_vld = '0;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 1'b1, AW'(k + 1), vals[k]);
      tick();
    end
    for (int c = 0; c < NC; c++) begin
      if (c < 3) set_req(0, 1'b1, 1'b0, AW'(c + 1), '0);
      else set_req(0, 1'b0, 1'b0, '0, '0);
      #1;
      ov[c] = rd_vld[0];
      od[c] = rd_dat;
      tick();
    end
    for (int c = 0; c < NC; c++) begin
      logic ev;
      ev = (c >= 1 + RDLAT) && (c < 4 + RDLAT);
      checks++;
      if (ov[c] !== ev) begin failures++; $display("FAIL b2b_vld c=%0d got=%b exp=%b", c, ov[c], ev); end
      if (ev) begin
        checks++;
        if (od[c] !== vals[c-1-RDLAT]) begin
          failures++;
          $display("FAIL b2b_dat c=%0d got=%h exp=%h", c, od[c], vals[c-1-RDLAT]);
        end
      end
    end
  endtask

  task automatic test_clear();
    logic [NREQ-1:0] e;
    set_req(0, 1'b1, 1'b0, AW'(2), '0);
    tick();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, AW'(8 + i), DW'($urandom));
    ram_clrrdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (req_rdy !== '0) begin failures++; $display("FAIL clr_rdy c=%0d got=%b exp=0", c, req_rdy); end
      checks++;
      if (ram_we !== 1'b0) begin failures++; $display("FAIL clr_we c=%0d got=%b exp=0", c, ram_we); end
      tick();
    end
    ram_clrrdy = 1'b1;
    e = model_gnt(req_vld, m_ptr, 1'b1);
    #1;
    checks++;
    if (req_rdy !== e || e == '0) begin failures++; $display("FAIL clr_resume got=%b exp=%b", req_rdy, e); end
    tick();
    req_vld = '0;
    repeat (RDLAT + 2) tick();
  endtask

  task automatic test_reset_midop();
    req_vld = '0;
    set_req(0, 1'b1, 1'b0, AW'(3), '0);
    tick();
    req_vld = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_din} !== '0) begin
      failures++;
      $display("FAIL mid_rst_cmd got=%b/%h/%h exp=0/000/0000", ram_we, ram_addr, ram_din);
    end
    checks++;
    if (rd_vld !== '0 || req_rdy !== '0) begin
      failures++;
      $display("FAIL mid_rst_out got=%b/%b exp=0/0", rd_vld, req_rdy);
    end
    for (int c = 0; c < RDLAT + 2; c++) begin
      tick();
      checks++;
      if (rd_vld !== '0) begin failures++; $display("FAIL mid_rst_rdvld c=%0d got=%b exp=0", c, rd_vld); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g;
    req_vld = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_vld[i] || g[i] || n == 0)
          set_req(i, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), DW'($urandom));
      end
      ram_clrrdy = ($urandom_range(0, 19) != 0);
      g = model_gnt(req_vld, m_ptr, ram_clrrdy);
      #1;
      checks++;
      if (req_rdy !== g) begin failures++; $display("FAIL rand_rdy n=%0d got=%b exp=%b", n, req_rdy, g); end
      tick();
    end
    req_vld = '0;
    ram_clrrdy = 1'b1;
    repeat (RDLAT + 3) tick();
    checks++;
    if (expq.size() != 0) begin failures++; $display("FAIL rand_drain pending=%0d exp=0", expq.size()); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    test_reset();
    test_rr_start();
    test_wr_rd();
    test_back_to_back();
    test_clear();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sp_ram_arb.md
Name: sp_ram_arb

Overview:
- Round-robin arbiter sharing one single-port RAM (sp_ram instance, any G_TYPE/G_PIPELINE) among G_NREQ requesters.
- Grants at most one access per cycle, registers the RAM command and tags each read.
- Returns read data to the issuing requester after the fixed RAM latency.
- Stalls all requesters while the RAM clear sequence runs (clrrdy low).

Parameters:
- G_NREQ, 2, number of requesters (2..8).
- G_ADDR, 10, RAM address width.
- G_WIDTH, 16, RAM data width.
- G_RDLAT, 1, RAM address-to-dout latency in cycles. Equals the RAM's G_PIPELINE for INFER/LUT builds; set to the true figure for BLOCK builds.
- G_IDW, clog2(G_NREQ) (min 1), requester-id width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- req_vld  in  G_NREQ  per-requester access request
- req_we  in  G_NREQ  1 = write, 0 = read
- req_addr  in  G_NREQ*G_ADDR  packed addresses; requester i at [i*G_ADDR +: G_ADDR]
- req_din  in  G_NREQ*G_WIDTH  packed write data
- req_rdy  out  G_NREQ  one-hot grant (combinational); access accepted when req_vld[i] & req_rdy[i]
- rd_vld  out  G_NREQ  one-hot read-return strobe
- rd_dat  out  G_WIDTH  read data, shared bus, qualified by rd_vld
- ram_clrrdy  in  1  from RAM clrrdy; 0 = clear in progress
- ram_we  out  1  to RAM we
- ram_addr  out  G_ADDR  to RAM addr
- ram_din  out  G_WIDTH  to RAM din
- ram_dout  in  G_WIDTH  from RAM dout

Clock/reset: one clock, clk. Reset is asynchronous, active low, on rst_n.

Behaviour:
- Reset values:
  - ram_we = 0, ram_addr = 0, ram_din = 0.
  - rd_vld = 0.
  - Tag pipeline cleared.
  - RR pointer = G_NREQ-1, so requester 0 wins first.
- req_rdy is forced to 0 while rst_n = 0 or ram_clrrdy = 0.
- Arbitration:
  - Search starts at (pointer+1) mod G_NREQ and wraps; the first requester with req_vld set is granted.
  - At most one req_rdy bit is high per cycle.
  - The pointer updates to the granted index only on a grant; otherwise it holds.
- req_rdy depends only on req_vld, pointer and ram_clrrdy, never on req_we/req_addr.
- Command stage: the accepted access is registered in cycle T+1.
  - ram_we = req_we, ram_addr = req_addr, ram_din = req_din.
  - With no grant: ram_we = 0, ram_addr/ram_din hold their last values.
- Read return:
  - A read accepted in cycle T pushes {valid, id} into a tag shift register G_RDLAT+1 deep.
  - rd_vld[id] is high in cycle T+1+G_RDLAT.
  - rd_dat = ram_dout passes straight through, unregistered.
  - Writes push valid = 0 and never produce rd_vld.
- Throughput: one access per cycle. Back-to-back reads return back to back, in grant order.
- Simultaneous requests: all losers keep req_vld held. Requesters must not drop or change req_addr/req_we/req_din while req_vld is high and req_rdy is low.
- Write then read, same address, consecutive grants: the read returns the new data. The RAM is clocked in order with no hazard logic.
- ram_clrrdy falls mid-stream:
  - No new grants from that cycle on.
  - In-flight reads still complete and return.
  - Their data may be the clear value.
- Reset asserted mid-operation: in-flight reads are discarded and no rd_vld is issued for them.
- Single requester active: it is granted every cycle it requests.

Optional Feature:
- Macro: SP_RAM_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has absolute priority and is granted whenever req_vld[0] = 1.
  - Requesters 1..G_NREQ-1 round-robin among themselves.
  - The pointer is not updated by a requester-0 grant.
- Undefined: plain round-robin over all requesters, as above.

Decomposition:
- Shared package sp_ram_pkg holds:
  - clog2 function for G_IDW.
  - Tag record width constant (1+G_IDW).
  - Packed-port slice helper functions.
- Sub-module rr_arb: G_NREQ request vector plus pointer in, one-hot grant out, with the priority-0 option. It is combinational; the pointer register lives in sp_ram_arb.

Test Plan (G_NREQ=2, G_WIDTH=16, G_RDLAT=1 unless stated):
- Reset release, req_vld=00 -> ram_we=0, rd_vld=00, req_rdy=00; then req_vld=11 -> req_rdy=01 first, 10 next cycle, alternating.
- Req0 writes 0x1234 to addr 5 at T; req1 reads addr 5 at T+1 -> rd_vld=10 with rd_dat=0x1234 at T+3; no rd_vld at T+2.
- G_RDLAT=3, req0 issues reads of addr 1,2,3 back to back -> rd_vld[0] high for 3 consecutive cycles starting 4 cycles after the first grant, data in address order.
- ram_clrrdy=0 for 10 cycles with req_vld=11 -> req_rdy=00 and ram_we=0 throughout; grants resume the cycle ram_clrrdy=1.
- Read granted, then rst_n pulsed low the next cycle -> rd_vld stays 00 and outputs return to reset values immediately.
- SP_RAM_ARB_PRIO0_EN defined, G_NREQ=3, req_vld=111 for 4 cycles -> req_rdy=001 every cycle; drop req0 -> 010, 100, 010, ...
